// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - RV32M divide/remainder sequencer in front of a shared unsigned divider
module div_sequencer #(
  parameter int XLEN = 32,
  parameter int ID_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_new_request,
  input  logic [XLEN-1:0] issue_rs1,
  input  logic [XLEN-1:0] issue_rs2,
  input  logic [1:0]      issue_op,
  input  logic [ID_W-1:0] issue_id,
  output logic            issue_ready,
  output logic            div_start,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder,
  input  logic            div_done,
  output logic            wb_done,
  output logic [ID_W-1:0] wb_id,
  output logic [XLEN-1:0] wb_rd,
  input  logic            wb_ack
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]      r_state;
  logic            r_is_rem;
  logic            r_neg_a;
  logic            r_neg_b;
  logic [XLEN-1:0] r_dividend;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_wb_rd;
  logic [ID_W-1:0] r_wb_id;

  // op[0] set means unsigned (DIVU/REMU), op[1] set means remainder (REM/REMU)
  logic            w_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic            w_div_by_zero;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic [XLEN-1:0] w_result;

  assign w_signed      = ~issue_op[0];
  assign w_neg_a       = w_signed & issue_rs1[XLEN-1];
  assign w_neg_b       = w_signed & issue_rs2[XLEN-1];
  assign w_div_by_zero = (issue_rs2 == '0);
  // Negating the most negative value wraps back to itself, which is the right unsigned magnitude
  assign w_mag_a       = w_neg_a ? -issue_rs1 : issue_rs1;
  assign w_mag_b       = w_neg_b ? -issue_rs2 : issue_rs2;

  always_comb begin
    w_result = '0;
    if (r_is_rem) begin
      w_result = r_neg_a ? -div_remainder : div_remainder;
    end else begin
      w_result = (r_neg_a ^ r_neg_b) ? -div_quotient : div_quotient;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_is_rem   <= 1'b0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_wb_rd    <= '0;
      r_wb_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (issue_new_request) begin
            r_is_rem   <= issue_op[1];
            r_neg_a    <= w_neg_a;
            r_neg_b    <= w_neg_b;
            r_wb_id    <= issue_id;
            r_dividend <= w_mag_a;
            r_divisor  <= w_mag_b;
            if (w_div_by_zero) begin
              r_wb_rd <= issue_op[1] ? issue_rs1 : '1;
              r_state <= S_WB;
            end else begin
              r_state <= S_START;
            end
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (div_done) begin
            r_wb_rd <= w_result;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (wb_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign issue_ready  = (r_state == S_IDLE);
  assign div_start    = (r_state == S_START);
  assign wb_done      = (r_state == S_WB);
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign wb_rd        = r_wb_rd;
  assign wb_id        = r_wb_id;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed table-driven bench for div_sequencer with a fixed-latency divider model
module tb_div_sequencer;
  localparam int XLEN = 32;
  localparam int ID_W = 3;
  localparam int L    = 33;
  localparam int NV   = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_new_request;
  logic [XLEN-1:0] issue_rs1;
  logic [XLEN-1:0] issue_rs2;
  logic [1:0]      issue_op;
  logic [ID_W-1:0] issue_id;
  logic            issue_ready;
  logic            div_start;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic [XLEN-1:0] div_quotient;
  logic [XLEN-1:0] div_remainder;
  logic            div_done;
  logic            wb_done;
  logic [ID_W-1:0] wb_id;
  logic [XLEN-1:0] wb_rd;
  logic            wb_ack;

  logic            m_done = 1'b0;
  logic            m_busy = 1'b0;
  int              m_cnt = 0;
  logic [XLEN-1:0] m_q = '0;
  logic [XLEN-1:0] m_r = '0;
  logic            inj_done = 1'b0;
  logic            allow_viol = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_sequencer #(.XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .issue_new_request(issue_new_request), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_op(issue_op), .issue_id(issue_id), .issue_ready(issue_ready),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
    .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack)
  );

  // Unsigned divider: start in cycle 1 gives a one-cycle done pulse in cycle 1+L
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (!rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (div_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
      m_q    <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
      m_r    <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
    end else if (m_busy) begin
      if (m_cnt == L - 1) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  assign div_quotient  = m_q;
  assign div_remainder = m_r;
  assign div_done      = m_done | inj_done;

  always @(posedge clk) begin
    if (rst && issue_new_request && !issue_ready && !allow_viol)
      $error("protocol error: issue_new_request while issue_ready=0");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  id;
    logic [31:0] rd;
    int          lat;
    int          starts;
    logic [31:0] dvd;
    logic [31:0] dvs;
  } vec_t;

  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] id, output logic [31:0] rd, output logic [2:0] wid,
                        output int lat, output int starts, output logic [31:0] dvd,
                        output logic [31:0] dvs, output int unstable);
    issue_op = op; issue_rs1 = a; issue_rs2 = b; issue_id = id;
    issue_new_request = 1'b1;
    tick();
    issue_new_request = 1'b0;
    lat = 1; starts = 0; dvd = '0; dvs = '0; unstable = 0;
    while (!wb_done && lat < 200) begin
      if (div_start) begin
        starts++;
        dvd = div_dividend;
        dvs = div_divisor;
      end else if (starts > 0 && (div_dividend !== dvd || div_divisor !== dvs)) begin
        unstable++;
      end
      tick();
      lat++;
    end
    rd  = wb_rd;
    wid = wb_id;
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, dvd, dvs;
    logic [2:0]  wid;
    int          lat, starts, unstable, seen, n;

    vecs[0]  = '{2'd0, 32'hFFFFFFF9, 32'd2,        3'd5, 32'hFFFFFFFD, 35, 1, 32'd7,        32'd2};
    vecs[1]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        3'd1, 32'hFFFFFFFF, 35, 1, 32'd7,        32'd2};
    vecs[2]  = '{2'd1, 32'd100,      32'd7,        3'd2, 32'd14,       35, 1, 32'd100,      32'd7};
    vecs[3]  = '{2'd3, 32'd100,      32'd7,        3'd3, 32'd2,        35, 1, 32'd100,      32'd7};
    vecs[4]  = '{2'd0, 32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h80000000, 35, 1, 32'h80000000, 32'd1};
    vecs[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 3'd6, 32'd0,        35, 1, 32'h80000000, 32'd1};
    vecs[6]  = '{2'd0, 32'd5,        32'd0,        3'd7, 32'hFFFFFFFF, 1,  0, 32'd0,        32'd0};
    vecs[7]  = '{2'd2, 32'd5,        32'd0,        3'd0, 32'd5,        1,  0, 32'd0,        32'd0};
    vecs[8]  = '{2'd3, 32'hFFFFFFF0, 32'd0,        3'd3, 32'hFFFFFFF0, 1,  0, 32'd0,        32'd0};
    vecs[9]  = '{2'd0, 32'd20,       32'hFFFFFFFD, 3'd2, 32'hFFFFFFFA, 35, 1, 32'd20,       32'd3};
    vecs[10] = '{2'd2, 32'd20,       32'hFFFFFFFD, 3'd1, 32'd2,        35, 1, 32'd20,       32'd3};
    vecs[11] = '{2'd1, 32'hFFFFFFF9, 32'd2,        3'd4, 32'h7FFFFFFC, 35, 1, 32'hFFFFFFF9, 32'd2};
    vecs[12] = '{2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 3'd5, 32'hFFFFFFFF, 35, 1, 32'd7,        32'd2};

    rst = 1'b0; issue_new_request = 1'b0; issue_rs1 = '0; issue_rs2 = '0;
    issue_op = '0; issue_id = '0; wb_ack = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    chk("reset_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("reset_div_start",   {31'd0, div_start},   32'd0);
    chk("reset_wb_done",     {31'd0, wb_done},     32'd0);
    chk("reset_dividend",    div_dividend,         32'd0);
    chk("reset_divisor",     div_divisor,          32'd0);
    chk("reset_wb_id",       {29'd0, wb_id},       32'd0);
    chk("reset_wb_rd",       wb_rd,                32'd0);
    repeat (2) tick();
    chk("ack_in_idle_wb_done", {31'd0, wb_done}, 32'd0);
    chk("ack_in_idle_ready",   {31'd0, issue_ready}, 32'd1);
    wb_ack = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].id, rd, wid, lat, starts, dvd, dvs, unstable);
      chk($sformatf("v%0d_rd", i),     rd,                 vecs[i].rd);
      chk($sformatf("v%0d_id", i),     {29'd0, wid},       {29'd0, vecs[i].id});
      chk($sformatf("v%0d_lat", i),    lat,                vecs[i].lat);
      chk($sformatf("v%0d_starts", i), starts,             vecs[i].starts);
      if (vecs[i].starts > 0) begin
        chk($sformatf("v%0d_dividend", i), dvd, vecs[i].dvd);
        chk($sformatf("v%0d_divisor", i),  dvs, vecs[i].dvs);
        chk($sformatf("v%0d_stable", i),   unstable, 0);
      end
      chk($sformatf("v%0d_ready_after_ack", i), {30'd0, issue_ready, wb_done}, 32'd2);
    end

    issue_op = 2'd1; issue_rs1 = 32'd100; issue_rs2 = 32'd7; issue_id = 3'd6;
    issue_new_request = 1'b1;
    tick();
    issue_new_request = 1'b0;
    n = 1;
    while (!wb_done && n < 200) begin
      tick();
      n++;
    end
    chk("bp_reach_wb", n, 35);
    allow_viol = 1'b1;
    for (int c = 0; c < 5; c++) begin
      issue_new_request = 1'b1; issue_op = 2'd0; issue_rs1 = 32'd55; issue_rs2 = 32'd0; issue_id = 3'd1;
      tick();
      chk($sformatf("bp%0d_done_ready", c), {30'd0, wb_done, issue_ready}, 32'd2);
      chk($sformatf("bp%0d_rd", c), wb_rd, 32'd14);
      chk($sformatf("bp%0d_id", c), {29'd0, wb_id}, 32'd6);
    end
    issue_new_request = 1'b0;
    allow_viol = 1'b0;
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("bp_after_ack", {30'd0, issue_ready, wb_done}, 32'd2);
    run_op(2'd3, 32'd100, 32'd7, 3'd7, rd, wid, lat, starts, dvd, dvs, unstable);
    chk("bp_next_rd", rd, 32'd2);
    chk("bp_next_lat", lat, 35);

    issue_op = 2'd0; issue_rs1 = 32'hFFFFFFF9; issue_rs2 = 32'd2; issue_id = 3'd5;
    issue_new_request = 1'b1;
    tick();
    issue_new_request = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midwait_rst_ready",    {31'd0, issue_ready}, 32'd1);
    chk("midwait_rst_start",    {31'd0, div_start},   32'd0);
    chk("midwait_rst_wb_done",  {31'd0, wb_done},     32'd0);
    chk("midwait_rst_dividend", div_dividend,         32'd0);
    chk("midwait_rst_divisor",  div_divisor,          32'd0);
    chk("midwait_rst_wb_id",    {29'd0, wb_id},       32'd0);
    chk("midwait_rst_wb_rd",    wb_rd,                32'd0);
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (wb_done || !issue_ready) seen++;
    end
    chk("stale_done_ignored", seen, 0);
    run_op(2'd1, 32'd9, 32'd3, 3'd2, rd, wid, lat, starts, dvd, dvs, unstable);
    chk("post_rst_rd", rd, 32'd3);
    chk("post_rst_id", {29'd0, wid}, 32'd2);
    chk("post_rst_lat", lat, 35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
